// File: rtl/i2c_rx_fifo_writer.sv
// rtl/i2c_rx_fifo_writer.sv - I2C byte receiver pushing into the write side of the async RX FIFO
module i2c_rx_fifo_writer #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_EN  = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 wclk_i,
  input  logic                 wrst_ni,
  input  logic                 enable_i,
  input  logic                 scl_i,
  input  logic                 sda_i,
  input  logic                 wfull_i,
  input  logic                 w_almost_full_i,
  output logic                 winc_o,
  output logic [7:0]           wdata_o,
  output logic                 sda_oe_o,
  output logic                 scl_oe_o,
  output logic                 busy_o,
  output logic                 overflow_o,
  input  logic                 clr_ovf_i,
  output logic [CNT_WIDTH-1:0] byte_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_PUSH,
    ST_STRETCH,
    ST_ACK,
    ST_NACK
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   push;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  // Almost-full is status only; this block has no use for it.
  logic unused_almost_full;
  assign unused_almost_full = w_almost_full_i;

  // Synchronisers reset to the idle-bus level so releasing reset never looks like a START.
  always_ff @(posedge wclk_i or negedge wrst_ni) begin
    if (!wrst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_ff @(posedge wclk_i or negedge wrst_ni) begin
    if (!wrst_ni) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ovf_d      = ovf_q;
    push       = 1'b0;

    if (clr_ovf_i) ovf_d = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_RECV: begin
        if (scl_rise && (bit_cnt_q != 4'd8)) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
          if (!wfull_i) begin
            state_d = ST_PUSH;
          end else if (STRETCH_EN != 0) begin
            state_d = ST_STRETCH;
          end else begin
            state_d = ST_NACK;
            ovf_d   = 1'b1;
          end
        end
      end
      // Full can only reappear here if another writer shares the FIFO; fall back instead of writing.
      ST_PUSH: begin
        if (wfull_i) begin
          if (STRETCH_EN != 0) begin
            state_d = ST_STRETCH;
          end else begin
            state_d = ST_NACK;
            ovf_d   = 1'b1;
          end
        end else begin
          push       = 1'b1;
          byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
          state_d    = ST_ACK;
        end
      end
      ST_STRETCH: begin
        if (!wfull_i) state_d = ST_PUSH;
      end
      ST_ACK: begin
        if (scl_fall) begin
          state_d   = ST_RECV;
          bit_cnt_d = 4'd0;
        end
      end
      ST_NACK: begin
        if (scl_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus conditions override any bit-level progress decided above.
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d    = ST_RECV;
      bit_cnt_d  = 4'd0;
      byte_cnt_d = '0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end
  end

  assign winc_o     = push;
  assign wdata_o    = shift_q;
  assign sda_oe_o   = (state_q == ST_ACK);
  assign scl_oe_o   = (state_q == ST_STRETCH);
  assign busy_o     = (state_q != ST_IDLE);
  assign overflow_o = ovf_q;
  assign byte_cnt_o = byte_cnt_q;

endmodule

// File: tb/tb_i2c_rx_fifo_writer.sv
// tb/tb_i2c_rx_fifo_writer.sv - directed bench for i2c_rx_fifo_writer (stretch and NACK variants)
module tb_i2c_rx_fifo_writer;

  localparam int Q = 8;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       enable = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       wfull_a = 1'b0;
  logic       wfull_b = 1'b0;
  logic       afull = 1'b0;
  logic       clr_ovf = 1'b0;

  logic       winc_a, sda_oe_a, scl_oe_a, busy_a, overflow_a;
  logic [7:0] wdata_a, byte_cnt_a;
  logic       winc_b, sda_oe_b, scl_oe_b, busy_b, overflow_b;
  logic [7:0] wdata_b, byte_cnt_b;

  int checks = 0;
  int failures = 0;
  int npush_a = 0;
  int npush_b = 0;
  int viol = 0;
  logic winc_a_prev = 1'b0;
  logic winc_b_prev = 1'b0;
  logic [7:0] push_a[$];

  i2c_rx_fifo_writer #(.SYNC_STAGES(2), .STRETCH_EN(1), .CNT_WIDTH(8)) dut_a (
    .wclk_i(wclk), .wrst_ni(wrst_n), .enable_i(enable), .scl_i(scl), .sda_i(sda),
    .wfull_i(wfull_a), .w_almost_full_i(afull), .winc_o(winc_a), .wdata_o(wdata_a),
    .sda_oe_o(sda_oe_a), .scl_oe_o(scl_oe_a), .busy_o(busy_a), .overflow_o(overflow_a),
    .clr_ovf_i(clr_ovf), .byte_cnt_o(byte_cnt_a)
  );

  i2c_rx_fifo_writer #(.SYNC_STAGES(2), .STRETCH_EN(0), .CNT_WIDTH(8)) dut_b (
    .wclk_i(wclk), .wrst_ni(wrst_n), .enable_i(enable), .scl_i(scl), .sda_i(sda),
    .wfull_i(wfull_b), .w_almost_full_i(afull), .winc_o(winc_b), .wdata_o(wdata_b),
    .sda_oe_o(sda_oe_b), .scl_oe_o(scl_oe_b), .busy_o(busy_b), .overflow_o(overflow_b),
    .clr_ovf_i(clr_ovf), .byte_cnt_o(byte_cnt_b)
  );

  always #5 wclk = ~wclk;

  // Write-side scoreboard: record pushes, flag back-to-back strobes or writes into a full FIFO.
  always @(posedge wclk) begin
    if (winc_a) begin
      push_a.push_back(wdata_a);
      npush_a++;
    end
    if (winc_b) npush_b++;
    if ((winc_a && (winc_a_prev || wfull_a)) || (winc_b && (winc_b_prev || wfull_b))) viol++;
    winc_a_prev = winc_a;
    winc_b_prev = winc_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic i2c_start();
    sda = 1'b1; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b0; cyc(Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    cyc(Q);
    scl = 1'b1; cyc(2 * Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_clk(output logic oa, output logic ob);
    sda = 1'b1; cyc(Q);
    scl = 1'b1; cyc(Q);
    oa = sda_oe_a;
    ob = sda_oe_b;
    cyc(Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic stop_bus(output int lat);
    sda = 1'b0; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b1;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge wclk);
      lat++;
      if (!busy_a) break;
    end
    cyc(Q);
  endtask

  function automatic logic [7:0] pop_a();
    if (push_a.size() == 0) return 8'hxx;
    return push_a.pop_front();
  endfunction

  logic oa, ob;
  int   lat;
  int   base_a, base_b;

  initial begin
    cyc(3);
    chk("rst_winc", winc_a, 0);
    chk("rst_sda_oe", sda_oe_a, 0);
    chk("rst_scl_oe", scl_oe_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovf", overflow_a, 0);
    chk("rst_cnt", byte_cnt_a, 0);
    wrst_n = 1'b1;
    cyc(10);
    chk("rst_no_false_start", busy_a, 0);

    // Single byte 0xA5
    i2c_start();
    chk("t1_busy", busy_a, 1);
    send_byte(8'hA5);
    ack_clk(oa, ob);
    chk("t1_ack_sda", oa, 1);
    chk("t1_npush", npush_a, 1);
    chk("t1_data", pop_a(), 8'hA5);
    chk("t1_cnt", byte_cnt_a, 1);
    chk("t1_sda_released", sda_oe_a, 0);
    stop_bus(lat);
    chk("t1_stop_lat", lat, 3);

    // Three bytes in order
    i2c_start();
    send_byte(8'h01); ack_clk(oa, ob);
    send_byte(8'h02); ack_clk(oa, ob);
    send_byte(8'h03); ack_clk(oa, ob);
    chk("t2_npush", npush_a, 4);
    chk("t2_d0", pop_a(), 8'h01);
    chk("t2_d1", pop_a(), 8'h02);
    chk("t2_d2", pop_a(), 8'h03);
    chk("t2_cnt", byte_cnt_a, 3);
    stop_bus(lat);
    chk("t2_stop_lat", lat, 3);
    chk("t2_busy_low", busy_a, 0);

    // Clock stretch while full
    i2c_start();
    for (int i = 7; i >= 1; i--) send_bit(logic'((8'h5A >> i) & 8'h01));
    wfull_a = 1'b1;
    send_bit(1'b0);
    chk("t3_stretch_on", scl_oe_a, 1);
    cyc(50);
    chk("t3_stretch_hold", scl_oe_a, 1);
    chk("t3_no_push_full", npush_a, 4);
    wfull_a = 1'b0;
    cyc(3);
    chk("t3_stretch_off", scl_oe_a, 0);
    chk("t3_npush", npush_a, 5);
    chk("t3_data", pop_a(), 8'h5A);
    ack_clk(oa, ob);
    chk("t3_ack_sda", oa, 1);
    chk("t3_no_ovf", overflow_a, 0);
    stop_bus(lat);

    // NACK and drop on the non-stretching instance
    wfull_b = 1'b1;
    base_b = npush_b;
    i2c_start();
    send_byte(8'h77);
    ack_clk(oa, ob);
    chk("t4_nack_sda", ob, 0);
    chk("t4_ovf_set", overflow_b, 1);
    chk("t4_no_push", npush_b, base_b);
    chk("t4_idle", busy_b, 0);
    chk("t4_a_data", pop_a(), 8'h77);
    clr_ovf = 1'b1; cyc(1);
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", overflow_b, 0);
    wfull_b = 1'b0;
    stop_bus(lat);

    // STOP after 5 bits, then repeated START mid-byte, then a clean byte
    base_a = npush_a;
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    stop_bus(lat);
    chk("t5_stop_no_push", npush_a, base_a);
    chk("t5_stop_idle", busy_a, 0);
    i2c_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    send_byte(8'h3C);
    ack_clk(oa, ob);
    chk("t5_npush", npush_a, base_a + 1);
    chk("t5_data", pop_a(), 8'h3C);
    chk("t5_cnt", byte_cnt_a, 1);
    stop_bus(lat);

    // Disable mid-byte
    base_a = npush_a;
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    enable = 1'b0;
    cyc(4);
    chk("t6_dis_idle", busy_a, 0);
    enable = 1'b1;
    stop_bus(lat);
    chk("t6_no_push", npush_a, base_a);

    // Reset during ACK
    i2c_start();
    send_byte(8'h99);
    chk("t7_data", pop_a(), 8'h99);
    base_a = npush_a;
    sda = 1'b1; cyc(Q);
    scl = 1'b1; cyc(4);
    chk("t7_in_ack", sda_oe_a, 1);
    wrst_n = 1'b0;
    #1;
    chk("t7_rst_sda", sda_oe_a, 0);
    chk("t7_rst_winc", winc_a, 0);
    chk("t7_rst_scl", scl_oe_a, 0);
    chk("t7_rst_busy", busy_a, 0);
    chk("t7_rst_cnt", byte_cnt_a, 0);
    cyc(3);
    wrst_n = 1'b1;
    cyc(20);
    chk("t7_no_false_start", busy_a, 0);
    chk("t7_no_push", npush_a, base_a);

    chk("winc_rules", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
